sport1_clkfs_gen: RTL and testbench

SPORT1_CLKFS_GEN -- requirements
Module: sport1_clkfs_gen

---
 rtl/sport1_clkfs_gen.sv | 66 ++++++
 tb/tb_sport1_clkfs_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sport1_clkfs_gen.sv
// sport1_clkfs_gen: SPORT1 internal serial clock and transmit frame sync generator
module sport1_clkfs_gen #(
  parameter int CNT_W = 16
) (
  input  logic             DSPCLK,
  input  logic             RST,
  input  logic             SPEN,
  input  logic             ISCLK,
  input  logic             INVxSCLK,
  input  logic             ITFS,
  input  logic             INVTFS,
  input  logic [CNT_W-1:0] SCLKDIV,
  input  logic [CNT_W-1:0] FSDIV,
  input  logic             SCLKDIV_we,
  output logic             SCLK_o,
  output logic             SCLK_rise,
  output logic             SCLK_fall,
  output logic             TFS_o,
  output logic             FS_pulse,
  output logic             BUSY
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t state, state_n;
  logic sclk, tfs, sclk_n, tfs_n, rise_n, fall_n, fs_n;
  logic [CNT_W-1:0] cnt, fcnt, cnt_n, fcnt_n;
  logic en, go, tgl, up;
  always_ff @(posedge DSPCLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    en      = SPEN & ISCLK;
    go      = (state == RUN) & en;
    tgl     = go & ~SCLKDIV_we & (cnt == '0);
    up      = tgl & ~sclk;
    state_n = en ? RUN : IDLE;
    sclk_n  = go & (sclk ^ tgl);
    cnt_n   = (!go || SCLKDIV_we || cnt == '0) ? SCLKDIV : cnt - ONE;
    fcnt_n  = !go ? '0 : up ? ((fcnt == '0) ? FSDIV : fcnt - ONE) : fcnt;
    tfs_n   = go & (up ? (fcnt == '0) : tfs);
    rise_n  = up;
    fall_n  = tgl & sclk;
    fs_n    = up & (fcnt == '0);
  end
  always_ff @(posedge DSPCLK or negedge RST)
    if (!RST) begin
      sclk      <= 1'b0;
      tfs       <= 1'b0;
      cnt       <= '0;
      fcnt      <= '0;
      SCLK_rise <= 1'b0;
      SCLK_fall <= 1'b0;
      FS_pulse  <= 1'b0;
    end else begin
      sclk      <= sclk_n;
      tfs       <= tfs_n;
      cnt       <= cnt_n;
      fcnt      <= fcnt_n;
      SCLK_rise <= rise_n;
      SCLK_fall <= fall_n;
      FS_pulse  <= fs_n;
    end
  assign BUSY   = (state == RUN);
  assign SCLK_o = sclk ^ INVxSCLK;
  assign TFS_o  = (tfs & ITFS) ^ INVTFS;
endmodule

// File: tb/tb_sport1_clkfs_gen.sv
// tb_sport1_clkfs_gen: directed scoreboard bench for the SPORT1 clock/frame-sync generator
module tb_sport1_clkfs_gen;
  localparam int CNT_W = 16;
  logic DSPCLK = 0, RST = 0, SPEN = 0, ISCLK = 0, INVxSCLK = 0, ITFS = 0, INVTFS = 0, SCLKDIV_we = 0;
  logic [CNT_W-1:0] SCLKDIV = '0, FSDIV = '0;
  logic SCLK_o, SCLK_rise, SCLK_fall, TFS_o, FS_pulse, BUSY;
  int checks = 0, errors = 0;
  typedef struct {logic sclk_o, tfs_o, rise, fall, fs, busy;} exp_t;
  exp_t q[$];

  sport1_clkfs_gen #(.CNT_W(CNT_W)) dut (
    .DSPCLK(DSPCLK), .RST(RST), .SPEN(SPEN), .ISCLK(ISCLK), .INVxSCLK(INVxSCLK),
    .ITFS(ITFS), .INVTFS(INVTFS), .SCLKDIV(SCLKDIV), .FSDIV(FSDIV), .SCLKDIV_we(SCLKDIV_we),
    .SCLK_o(SCLK_o), .SCLK_rise(SCLK_rise), .SCLK_fall(SCLK_fall), .TFS_o(TFS_o),
    .FS_pulse(FS_pulse), .BUSY(BUSY)
  );

  always #5 DSPCLK = ~DSPCLK;

  task automatic step();
    @(posedge DSPCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic push(input logic s, input logic t, input logic r, input logic f, input logic p, input logic b);
    exp_t e;
    e.sclk_o = s; e.tfs_o = t; e.rise = r; e.fall = f; e.fs = p; e.busy = b;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    step();
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".sclk_o"}, SCLK_o, e.sclk_o);
      chk({tag, ".tfs_o"}, TFS_o, e.tfs_o);
      chk({tag, ".rise"}, SCLK_rise, e.rise);
      chk({tag, ".fall"}, SCLK_fall, e.fall);
      chk({tag, ".fs"}, FS_pulse, e.fs);
      chk({tag, ".busy"}, BUSY, e.busy);
    end
  endtask

  // Enable from IDLE and predict N+1 cycles in closed form: edge 0 is the IDLE->RUN edge.
  task automatic run_seq(input string tag, input int d, input int f, input int n_max,
                         input logic is, input logic it, input logic itfs);
    SCLKDIV = CNT_W'(d); FSDIV = CNT_W'(f); INVxSCLK = is; INVTFS = it; ITFS = itfs;
    SPEN = 1; ISCLK = 1;
    for (int n = 0; n <= n_max; n++) begin
      int m, r;
      logic tg, s, rs, fl, fp, tf;
      m  = n / (d + 1);
      tg = (n > 0) && (n % (d + 1) == 0);
      s  = m[0];
      rs = tg && s;
      fl = tg && !s;
      r  = (m + 1) / 2;
      fp = rs && ((r - 1) % (f + 1) == 0);
      tf = (r >= 1) && ((r - 1) % (f + 1) == 0);
      push(s ^ is, (tf & itfs) ^ it, rs, fl, fp, 1'b1);
    end
    for (int n = 0; n <= n_max; n++) pop_check($sformatf("%s[%0d]", tag, n));
  endtask

  task automatic stop(input string tag);
    SPEN = 0;
    step();
    chk({tag, ".busy"}, BUSY, 1'b0);
    chk({tag, ".sclk_o"}, SCLK_o, INVxSCLK);
    step();
  endtask

  initial begin
    INVxSCLK = 1; INVTFS = 1;
    #1;
    chk("rst.sclk_o_inv", SCLK_o, 1'b1);
    chk("rst.tfs_o_inv", TFS_o, 1'b1);
    chk("rst.busy", BUSY, 1'b0);
    chk("rst.rise", SCLK_rise, 1'b0);
    chk("rst.fs", FS_pulse, 1'b0);
    step();
    INVxSCLK = 0; INVTFS = 0; SPEN = 1; ISCLK = 1;
    #1;
    chk("rst.sclk_o", SCLK_o, 1'b0);
    chk("rst.tfs_o", TFS_o, 1'b0);
    step();
    chk("rst.hold_busy", BUSY, 1'b0);
    SPEN = 0; ISCLK = 0;
    @(negedge DSPCLK) RST = 1;
    step();
    chk("idle.busy", BUSY, 1'b0);
    ISCLK = 1;
    step();
    chk("idle.isclk_only", BUSY, 1'b0);
    ISCLK = 0; SPEN = 1;
    step();
    chk("idle.ext_sclk", BUSY, 1'b0);
    SPEN = 0;

    run_seq("div3_fs2", 3, 2, 60, 0, 0, 1);
    stop("stop1");
    run_seq("div0_fs0", 0, 0, 12, 0, 0, 1);
    stop("stop2");
    run_seq("inv_noitfs", 1, 1, 16, 1, 1, 0);
    stop("stop3");
    INVxSCLK = 0; INVTFS = 0;

    // Rewrite the divisor while the count is 5: reload without toggling.
    run_seq("div7_pre", 7, 3, 2, 0, 0, 1);
    SCLKDIV = 1; SCLKDIV_we = 1;
    push(0, 0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0, 1);
    push(1, 1, 1, 0, 1, 1);
    push(1, 1, 0, 0, 0, 1);
    push(0, 1, 0, 1, 0, 1);
    push(0, 1, 0, 0, 0, 1);
    push(1, 0, 1, 0, 0, 1);
    push(1, 0, 0, 0, 0, 1);
    pop_check("we[3]");
    SCLKDIV_we = 0;
    for (int i = 4; i <= 10; i++) pop_check($sformatf("we[%0d]", i));

    // Drop SPEN with sclk high: abandon without a fall pulse.
    SPEN = 0;
    push(0, 0, 0, 0, 0, 0);
    pop_check("drop");
    run_seq("reen", 1, 3, 10, 0, 0, 1);

    // Asynchronous reset away from any clock edge, sclk currently high.
    #2 RST = 0;
    #1;
    chk("arst.sclk_o", SCLK_o, 1'b0);
    chk("arst.busy", BUSY, 1'b0);
    chk("arst.rise", SCLK_rise, 1'b0);
    chk("arst.fall", SCLK_fall, 1'b0);
    chk("arst.fs", FS_pulse, 1'b0);
    SPEN = 0;
    @(negedge DSPCLK) RST = 1;
    step();
    step();
    chk("arst.idle", BUSY, 1'b0);
    run_seq("post_rst", 2, 1, 30, 0, 0, 1);
    stop("stop4");
    if (q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL queue_leftover observed=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
